result_axis_packer: RTL
=======================

Name: result_axis_packer

Overview:
- Output stage directly downstream of the detection core.
- Consumes the core's unflow-controlled result stream (signal_out_data / signal_out_valid) and buffers it in a FIFO.
- Re-emits the buffered words as an AXI4-Stream master toward the output DMA, marking end-of-frame with tlast.
- Provides an almost-full indication the top level uses to throttle pixel intake (gating fifo_rd_en); flags any dropped word.

Parameters:
- DATA_W, 32, width of result word and m_axis_tdata
- FIFO_DEPTH, 64, total buffering in words, output register included; power of 2, >= 4
- AF_MARGIN, 8, almost_full asserts when occupancy >= FIFO_DEPTH - AF_MARGIN
- FRAME_LEN, 4096, result words per frame; tlast on word FRAME_LEN-1; >= 1

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- in_data  in  DATA_W  result word from core (signal_out_data)
- in_valid  in  1  result word strobe (signal_out_valid); no ready, cannot be stalled
- m_axis_tdata  out  DATA_W  output word
- m_axis_tvalid  out  1  output valid
- m_axis_tready  in  1  downstream ready
- m_axis_tlast  out  1  last word of frame
- almost_full  out  1  throttle hint to top level
- occupancy  out  $clog2(FIFO_DEPTH)+1  words held, output register included
- overflow  out  1  sticky: a word was dropped
- overflow_clr  in  1  clears overflow
- frame_done  out  1  one-cycle pulse after the tlast handshake
- frame_count  out  32  completed frames (STATS only)
- max_occupancy  out  $clog2(FIFO_DEPTH)+1  high-water mark (STATS only)

Behaviour:
- Reset (rst high at a clk edge): every output is 0; FIFO empties; word index resets to 0. Reset mid-frame discards buffered data and any partial frame.
- Write: on in_valid with occupancy < FIFO_DEPTH, the word is stored.
  - Full is judged on the registered occupancy. A write at occupancy == FIFO_DEPTH is dropped, even if a pop happens in the same cycle.
  - A dropped write sets overflow on the next edge. overflow stays 1 until overflow_clr.
  - If overflow_clr and a drop coincide, overflow stays 1 (set wins).
- Output register: m_axis_tvalid/tdata are registered.
  - A word written into an empty block appears with m_axis_tvalid=1 on the following cycle (1-cycle latency).
  - Once tvalid=1, tdata and tlast hold until a handshake (tvalid & tready).
  - Back-to-back handshakes sustain 1 word/cycle when data is present.
- Occupancy: +1 on an accepted write, -1 on a handshake, unchanged when both occur.
- almost_full: combinational compare of registered occupancy against FIFO_DEPTH - AF_MARGIN.
- Word index:
  - Counts handshakes 0..FRAME_LEN-1 and wraps to 0.
  - m_axis_tlast = (index == FRAME_LEN-1) whenever tvalid=1; otherwise 0.
  - Dropped words are not counted, so tlast positions follow delivered words only.
- frame_done: registered, high for exactly one cycle after the tlast handshake.
- FRAME_LEN=1: every word carries tlast.

Optional Feature:
- Macro: RESULT_AXIS_PACKER_STATS_EN.
- Defined:
  - frame_count increments with each frame_done and wraps at 2^32.
  - max_occupancy tracks the peak occupancy since reset.
  - Both clear on rst.
- Undefined:
  - Both ports are tied to constant 0; no counter logic is synthesized.
  - All other behaviour is identical.

Test Plan:
- Latency and tlast (FRAME_LEN=8, tready=1): 8 writes of 0x00000001..0x00000008 -> tvalid 1 cycle after first write; 8 handshakes; tlast only on 0x00000008; frame_done pulses once.
- Backpressure (tready=0, 20 writes 0xA0..0xB3): occupancy=20; tdata holds 0xA0. Then tready=1 -> 20 words in order, 1 per cycle; occupancy returns to 0.
- Almost full (FIFO_DEPTH=64, AF_MARGIN=8, tready=0): almost_full=0 at 55 words and 1 at 56. At 64 a 65th write 0xDEAD is dropped, overflow=1, occupancy stays 64, 0xDEAD never appears.
- Overflow clear: overflow_clr pulse with no drop -> overflow=0. Clear coincident with a drop -> overflow stays 1.
- Reset mid-frame (FRAME_LEN=8): after 3 handshakes and 5 buffered words, assert rst 1 cycle -> all outputs 0. A new 8-word frame gives tlast on its 8th word.
- STATS_EN defined (FRAME_LEN=4): 3 frames -> frame_count=3, max_occupancy equals the observed peak. Undefined: both read 0.

Source files
------------

// File: rtl/result_axis_packer.sv
// rtl/result_axis_packer.sv - Buffers the unflow-controlled result stream and re-emits it as an AXI4-Stream master.
// Optional statistics counters are enabled by defining RESULT_AXIS_PACKER_STATS_EN.
module result_axis_packer #(
    parameter int DATA_W     = 32,
    parameter int FIFO_DEPTH = 64,
    parameter int AF_MARGIN  = 8,
    parameter int FRAME_LEN  = 4096
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [DATA_W-1:0]               in_data,
    input  logic                            in_valid,
    output logic [DATA_W-1:0]               m_axis_tdata,
    output logic                            m_axis_tvalid,
    input  logic                            m_axis_tready,
    output logic                            m_axis_tlast,
    output logic                            almost_full,
    output logic [$clog2(FIFO_DEPTH):0]     occupancy,
    output logic                            overflow,
    input  logic                            overflow_clr,
    output logic                            frame_done,
    output logic [31:0]                     frame_count,
    output logic [$clog2(FIFO_DEPTH):0]     max_occupancy
);

    localparam int OCC_W = $clog2(FIFO_DEPTH) + 1;
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int IDX_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
    localparam logic [OCC_W-1:0] DEPTH_C  = OCC_W'(FIFO_DEPTH);
    localparam logic [OCC_W-1:0] AF_TH    = OCC_W'(FIFO_DEPTH - AF_MARGIN);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);

    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic [OCC_W-1:0]  occ, occ_nxt, mem_count;
    logic [IDX_W-1:0]  idx;

    logic wr_ok, drop, pop, out_free, load_mem, bypass, mem_wr, is_last;

    // Full is judged on registered occupancy so a same-cycle pop never frees a slot.
    assign wr_ok    = in_valid && (occ != DEPTH_C);
    assign drop     = in_valid && (occ == DEPTH_C);
    assign pop      = m_axis_tvalid && m_axis_tready;
    assign out_free = !m_axis_tvalid || pop;
    assign load_mem = out_free && (mem_count != '0);
    // Writes into an idle block skip the memory to give one-cycle latency.
    assign bypass   = out_free && (mem_count == '0) && wr_ok;
    assign mem_wr   = wr_ok && !bypass;
    assign is_last  = (idx == LAST_IDX);

    assign m_axis_tlast = m_axis_tvalid && is_last;
    assign almost_full  = (occ >= AF_TH);
    assign occupancy    = occ;

    always_comb begin
        occ_nxt = occ;
        case ({wr_ok, pop})
            2'b10:   occ_nxt = occ + OCC_W'(1);
            2'b01:   occ_nxt = occ - OCC_W'(1);
            default: occ_nxt = occ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (mem_wr) begin
            mem[wr_ptr] <= in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            mem_count     <= '0;
            occ           <= '0;
            idx           <= '0;
            m_axis_tdata  <= '0;
            m_axis_tvalid <= 1'b0;
            frame_done    <= 1'b0;
            overflow      <= 1'b0;
        end else begin
            if (mem_wr) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (load_mem) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({mem_wr, load_mem})
                2'b10:   mem_count <= mem_count + OCC_W'(1);
                2'b01:   mem_count <= mem_count - OCC_W'(1);
                default: mem_count <= mem_count;
            endcase

            if (load_mem) begin
                m_axis_tdata  <= mem[rd_ptr];
                m_axis_tvalid <= 1'b1;
            end else if (bypass) begin
                m_axis_tdata  <= in_data;
                m_axis_tvalid <= 1'b1;
            end else if (pop) begin
                m_axis_tvalid <= 1'b0;
            end

            occ <= occ_nxt;

            if (pop) begin
                idx <= is_last ? '0 : idx + IDX_W'(1);
            end
            frame_done <= pop && is_last;

            if (drop) begin
                overflow <= 1'b1;
            end else if (overflow_clr) begin
                overflow <= 1'b0;
            end
        end
    end

`ifdef RESULT_AXIS_PACKER_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            frame_count   <= '0;
            max_occupancy <= '0;
        end else begin
            if (frame_done) begin
                frame_count <= frame_count + 32'd1;
            end
            if (occ_nxt > max_occupancy) begin
                max_occupancy <= occ_nxt;
            end
        end
    end
`else
    assign frame_count   = '0;
    assign max_occupancy = '0;
`endif

endmodule
